h75_fb_arbiter: RTL and testbench

H75_FB_ARBITER -- requirements
Module: h75_fb_arbiter

---
 rtl/h75_fb_arbiter_pkg.sv | 15 +
 rtl/h75_fb_arbiter_if.sv | 35 +++
 rtl/h75_fb_arbiter_rr_arb2.sv | 32 +++
 rtl/h75_fb_arbiter.sv | 120 ++++++++++++
 tb/tb_h75_fb_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/h75_fb_arbiter_pkg.sv
// h75_pkg: shared definitions for the H75 framebuffer write arbiter.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Holds default bus widths, the page-bit position of wr_addr and the FSM encoding.
package h75_pkg;

  localparam int H75_ADDR_W   = 15;          // per-page word address width
  localparam int H75_DATA_W   = 16;          // framebuffer word width
  localparam int H75_PAGE_BIT = H75_ADDR_W;  // wr_addr MSB selects the page

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } h75_state_e;

endpackage

// File: rtl/h75_fb_arbiter_if.sv
// h75_fb_arbiter_if: requester A/B valid-ready channels plus framebuffer write port.
// Latency: n/a (wires only). Backpressure: a_ready/b_ready driven by the arbiter.
// Modports: master = requester/memory side, slave = arbiter side.
interface h75_fb_arbiter_if
  import h75_pkg::*;
#(
  parameter int ADDR_W = H75_ADDR_W,
  parameter int DATA_W = H75_DATA_W
);

  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;

  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;

  logic              wr_en;
  logic [ADDR_W:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/h75_fb_arbiter_rr_arb2.sv
// h75_rr_arb2: two-requester round-robin grant with a registered last-winner pointer.
// Latency: grant is combinational from requests; pointer updates on the granted cycle.
// Backpressure: en_i=0 withholds both grants; the loser of a contested cycle wins next.
// Ports: clk, resetn (sync, active-low), en_i, req_a_i/req_b_i in; gnt_a_o/gnt_b_o out.
module h75_rr_arb2 (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // prio_b_q=1: B wins the next contested cycle. Reset leaves A in front.
  logic prio_b_q, prio_b_d;

  always_comb begin
    gnt_a_o  = en_i && req_a_i && (!req_b_i || !prio_b_q);
    gnt_b_o  = en_i && req_b_i && (!req_a_i ||  prio_b_q);
    prio_b_d = prio_b_q;
    // A grant always completes a transfer, since grants only go to valid requesters.
    if (gnt_a_o)      prio_b_d = 1'b1;
    else if (gnt_b_o) prio_b_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) prio_b_q <= 1'b0;
    else         prio_b_q <= prio_b_d;
  end

endmodule

// File: rtl/h75_fb_arbiter.sv
// h75_fb_arbiter: merges APB (A) and DMA (B) pixel writes into a double-buffered framebuffer,
// with frame-synchronous page swap and back-page zero-fill.
// Latency: accepted beat -> wr_en one cycle later. Backpressure: both readies low during CLEAR.
// Ports: clk, resetn (sync, active-low), frame_sync, swap_req, clear_req; bus (A/B channels and
// write port, slave modport); display_page, swap_pending, clear_busy status outputs.
module h75_fb_arbiter
  import h75_pkg::*;
#(
  parameter int ADDR_W = H75_ADDR_W,
  parameter int DATA_W = H75_DATA_W
)(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  frame_sync,
  input  logic                  swap_req,
  input  logic                  clear_req,
  h75_fb_arbiter_if.slave       bus,
  output logic                  display_page,
  output logic                  swap_pending,
  output logic                  clear_busy
);

  h75_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              disp_q, disp_d;
  logic              pend_q, pend_d;
  logic              wr_en_q;
  logic [ADDR_W:0]   wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic arb_en, clr_wr;
  logic gnt_a, gnt_b, beat, swap_fire;

  h75_rr_arb2 u_rr (
    .clk     (clk),
    .resetn  (resetn),
    .en_i    (arb_en),
    .req_a_i (bus.a_valid),
    .req_b_i (bus.b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;
  assign beat        = gnt_a || gnt_b;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // FSM next state: clear_req is only honoured from IDLE
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;  // wraps to 0 after the final address
        if (&clr_cnt_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; gating with resetn keeps the combinational readies low during reset
  always_comb begin
    arb_en     = resetn && (state_q == ST_IDLE);
    clr_wr     = (state_q == ST_CLEAR);
    clear_busy = resetn && (state_q == ST_CLEAR);
  end

  // Swap only on a frame boundary while no clear is running; a swap_req in the firing
  // cycle is absorbed by the swap it would have requested.
  always_comb begin
    swap_fire = frame_sync && pend_q && (state_q == ST_IDLE);
    disp_d    = disp_q ^ swap_fire;
    pend_d    = pend_q;
    if (swap_fire)     pend_d = 1'b0;
    else if (swap_req) pend_d = 1'b1;
  end

  // Writes always target the back page as seen in the accepting cycle (pre-swap).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      disp_q    <= 1'b0;
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      wr_en_q <= beat || clr_wr;
      if (beat) begin
        wr_addr_q <= {~disp_q, (gnt_a ? bus.a_addr : bus.b_addr)};
        wr_data_q <= gnt_a ? bus.a_data : bus.b_data;
      end else if (clr_wr) begin
        wr_addr_q <= {~disp_q, clr_cnt_q};
        wr_data_q <= '0;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign display_page = disp_q;
  assign swap_pending = pend_q;

endmodule

// File: tb/tb_h75_fb_arbiter.sv
// tb_h75_fb_arbiter: self-checking bench for h75_fb_arbiter.
// Latency: inputs driven 1 ns after posedge, outputs checked on negedge.
// Backpressure: a cycle model predicts readies; expected writes go through a scoreboard queue.
module tb_h75_fb_arbiter;
  import h75_pkg::*;

  localparam int AW = H75_ADDR_W;
  localparam int DW = H75_DATA_W;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_sync = 1'b0;
  logic swap_req = 1'b0;
  logic clear_req = 1'b0;
  logic display_page, swap_pending, clear_busy;

  h75_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  h75_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_sync   (frame_sync),
    .swap_req     (swap_req),
    .clear_req    (clear_req),
    .bus          (bus),
    .display_page (display_page),
    .swap_pending (swap_pending),
    .clear_busy   (clear_busy)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_zero_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: state of the current cycle, advanced at each negedge.
  bit              m_clr = 1'b0;
  logic [AW-1:0]   m_cnt = '0;
  bit              m_prio_b = 1'b0;
  bit              m_disp = 1'b0;
  bit              m_pend = 1'b0;
  logic [31:0]     sb_q[$];

  always @(negedge clk) begin : model
    logic        ea, eb, fire;
    logic [31:0] e;
    ea = resetn && !m_clr && bus.a_valid && (!bus.b_valid || !m_prio_b);
    eb = resetn && !m_clr && bus.b_valid && (!bus.a_valid ||  m_prio_b);
    check("a_ready", bus.a_ready, ea);
    check("b_ready", bus.b_ready, eb);
    check("clear_busy", clear_busy, resetn && m_clr);
    check("display_page", display_page, m_disp);
    check("swap_pending", swap_pending, m_pend);

    if (bus.wr_en === 1'b1) begin
      n_wr++;
      if (bus.wr_data == '0 && bus.wr_addr[H75_PAGE_BIT]) n_zero_hi++;
      if (sb_q.size() == 0) check("wr_unexpected", bus.wr_en, 1'b0);
      else begin
        e = sb_q.pop_front();
        check("sb_wr_addr", bus.wr_addr, e[31:16]);
        check("sb_wr_data", bus.wr_data, e[15:0]);
      end
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("wr_missing", bus.wr_en, 1'b1);
    end

    if (!resetn) begin
      m_clr = 1'b0; m_cnt = '0; m_prio_b = 1'b0; m_disp = 1'b0; m_pend = 1'b0;
      sb_q.delete();
    end else begin
      if (ea) begin
        sb_q.push_back({~m_disp, bus.a_addr, bus.a_data});
        m_prio_b = 1'b1;
      end else if (eb) begin
        sb_q.push_back({~m_disp, bus.b_addr, bus.b_data});
        m_prio_b = 1'b0;
      end
      if (m_clr) sb_q.push_back({~m_disp, m_cnt, 16'h0000});
      fire = frame_sync && m_pend && !m_clr;
      if (fire) begin
        m_disp = !m_disp;
        m_pend = 1'b0;
      end else if (swap_req) m_pend = 1'b1;
      if (m_clr) begin
        if (m_cnt == '1) m_clr = 1'b0;
        m_cnt = m_cnt + 1'b1;
      end else if (clear_req) m_clr = 1'b1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not reach the end, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, busy, saw_rdy;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_disp", display_page, 0);
    tick();
    resetn = 1'b1;
    tick();

    // Lone A beat
    bus.a_valid = 1'b1; bus.a_addr = 15'h0123; bus.a_data = 16'hBEEF;
    @(negedge clk); check("a_lone_grant", bus.a_ready, 1);
    tick(); bus.a_valid = 1'b0;
    @(negedge clk);
    check("w1_en", bus.wr_en, 1);
    check("w1_addr", bus.wr_addr, 16'h8123);
    check("w1_data", bus.wr_data, 16'hBEEF);

    // Lone B beat, which also puts A back in front
    tick();
    bus.b_valid = 1'b1; bus.b_addr = 15'h0042; bus.b_data = 16'h1111;
    @(negedge clk); check("b_lone_grant", bus.b_ready, 1);
    tick(); bus.b_valid = 1'b0;
    tick();

    // Contested: A,B,A,B
    bus.a_valid = 1'b1; bus.a_addr = 15'h0010; bus.a_data = 16'hA0A0;
    bus.b_valid = 1'b1; bus.b_addr = 15'h0020; bus.b_data = 16'hB0B0;
    nw = n_wr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_a", bus.a_ready, (i % 2 == 0));
      check("rr_b", bus.b_ready, (i % 2 == 1));
      tick();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    tick(); tick();
    check("rr_wr_cnt", n_wr - nw, 4);

    // Clear of back page 1 with A held valid
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    bus.a_valid = 1'b1; bus.a_addr = 15'h0055; bus.a_data = 16'h5A5A;
    n_zero_hi = 0; busy = 0; saw_rdy = 0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (!clear_busy) break;
      busy++;
      if (bus.a_ready) saw_rdy = 1;
      tick();
    end
    check("clr_cycles", busy, 32768);
    check("clr_rdy_blocked", saw_rdy, 0);
    check("clr_a_grant_after", bus.a_ready, 1);
    tick(); bus.a_valid = 1'b0;
    @(negedge clk); check("clr_a_wr_addr", bus.wr_addr, 16'h8055);
    tick();
    check("clr_zero_writes", n_zero_hi, 32768);

    // Swap: pending until frame_sync, beat in the swap cycle uses the old back page
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("swap_pend_hold", swap_pending, 1);
      check("swap_disp_hold", display_page, 0);
      tick();
    end
    frame_sync = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 15'h0066; bus.a_data = 16'h6666;
    tick(); frame_sync = 1'b0; bus.a_valid = 1'b0;
    @(negedge clk);
    check("swap_disp", display_page, 1);
    check("swap_pend_clr", swap_pending, 0);
    check("swap_cycle_wr_addr", bus.wr_addr, 16'h8066);
    tick();
    bus.a_valid = 1'b1; bus.a_addr = 15'h0077; bus.a_data = 16'h7777;
    tick(); bus.a_valid = 1'b0;
    @(negedge clk);
    check("post_swap_msb", bus.wr_addr[H75_PAGE_BIT], 0);
    check("post_swap_addr", bus.wr_addr, 16'h0077);
    tick();

    // swap_req and frame_sync during a clear: swap deferred to first frame_sync after it
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    repeat (50) tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (50) tick();
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    @(negedge clk);
    check("clr_no_swap_disp", display_page, 1);
    check("clr_swap_pend", swap_pending, 1);
    for (int i = 0; i < 40000 && clear_busy; i++) tick();
    @(negedge clk); check("clr2_done", clear_busy, 0);
    repeat (3) tick();
    check("clr2_disp_hold", display_page, 1);
    frame_sync = 1'b1; tick(); frame_sync = 1'b0;
    @(negedge clk);
    check("clr2_swap_disp", display_page, 0);
    check("clr2_swap_pend", swap_pending, 0);
    tick();

    // Reset at clear address 100, with a swap pending
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (99) tick();
    @(negedge clk); check("rst_clr_pos", bus.wr_addr, 16'h8063);
    resetn = 1'b0;
    tick();
    @(negedge clk);
    check("rst2_wr_en", bus.wr_en, 0);
    check("rst2_wr_addr", bus.wr_addr, 0);
    check("rst2_wr_data", bus.wr_data, 0);
    check("rst2_disp", display_page, 0);
    check("rst2_pend", swap_pending, 0);
    check("rst2_busy", clear_busy, 0);
    check("rst2_a_ready", bus.a_ready, 0);
    check("rst2_b_ready", bus.b_ready, 0);
    tick();
    resetn = 1'b1;
    nw = n_wr;
    repeat (20) tick();
    check("post_rst_no_wr", n_wr - nw, 0);
    check("post_rst_pend", swap_pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
